key_enc8_3: RTL and testbench

Debounced 8-to-3 priority key encoder: the encode-side counterpart of the team's active-low 3-to-8 decoder. Takes eight asynchronous active-low key/request lines, synchronizes and debounces them, and presents the index of the highest-priority asserted line as a 3-bit code. It also emits a one-cycle `valid` strobe on every change of the winning index and an active-low group-select. Sits between board push-buttons or active-low request lines and the decoder/display logic.

---
 rtl/key_enc8_3_if.sv | 12 +
 rtl/key_enc8_3.sv | 127 ++++++++++++
 tb/tb_key_enc8_3.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/key_enc8_3_if.sv
// Key-encoder signal bundle: active-low key lines and enable in, encoded
// winner, change strobe and group select out.
interface key_enc8_3_if;
    logic       en;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       valid;
    logic       gs_n;

    modport master (output en, output key_n, input code, input valid, input gs_n);
    modport slave  (input en, input key_n, output code, output valid, output gs_n);
endinterface

// File: rtl/key_enc8_3.sv
// Debounced 8-to-3 priority encoder for active-low keys: two-flop sync,
// whole-vector debounce, and a press/release FSM with registered outputs.
module key_enc8_3 #(
    parameter int unsigned DEB_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    key_enc8_3_if.slave  bus
);
    localparam int unsigned     CNT_W   = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {IDLE, PRESSED} state_t;

    logic [7:0]       sync1_q, sync1_d;
    logic [7:0]       sync2_q, sync2_d;
    logic [7:0]       cand_q, cand_d;
    logic [7:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             gs_n_q, gs_n_d;

    logic [2:0]       win;
    logic             any;

    // Synchronizer and debounce: any change of the synchronized vector restarts
    // the window; the counter saturates so a held vector keeps reloading stable.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sync1_d  = bus.key_n;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (!bus.en) begin
            sync1_d  = 8'hFF;
            sync2_d  = 8'hFF;
            cand_d   = 8'hFF;
            stable_d = 8'hFF;
            cnt_d    = '0;
        end
    end

    // Ascending scan so the highest low bit is the last to write win.
    always_comb begin
        win = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!stable_q[i]) win = 3'(i);
        end
        any = (stable_q != 8'hFF);
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
        gs_n_d  = gs_n_q;
        case (state_q)
            IDLE: begin
                gs_n_d = 1'b1;
                if (any) begin
                    code_d  = win;
                    valid_d = 1'b1;
                    gs_n_d  = 1'b0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                gs_n_d = 1'b0;
                if (!any) begin
                    gs_n_d  = 1'b1;
                    state_d = IDLE;
                end else if (win != code_q) begin
                    code_d  = win;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disabling drops back to idle but keeps the last reported code.
        if (!bus.en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            gs_n_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 8'hFF;
            sync2_q  <= 8'hFF;
            cand_q   <= 8'hFF;
            stable_q <= 8'hFF;
            cnt_q    <= '0;
            state_q  <= IDLE;
            code_q   <= 3'd0;
            valid_q  <= 1'b0;
            gs_n_q   <= 1'b1;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            gs_n_q   <= gs_n_d;
        end
    end

    assign bus.code  = code_q;
    assign bus.valid = valid_q;
    assign bus.gs_n  = gs_n_q;

endmodule

// File: tb/tb_key_enc8_3.sv
// Directed bench for key_enc8_3 with DEB_CYCLES=4: every press/release lands
// 7 edges after the first edge that samples the new key vector.
module tb_key_enc8_3;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    key_enc8_3_if bus ();

    key_enc8_3 #(.DEB_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Applies key at a falling edge, then records over n rising edges (edge 0
    // is the first to sample key) when valid, gs_n and code first move.
    task automatic observe(input logic [7:0] key, input int n,
                           output int v_edge, output int v_cnt,
                           output int gs_edge, output int code_edge,
                           output logic [2:0] code_o, output logic gs_o);
        logic       gs0;
        logic [2:0] code0;
        gs0 = bus.gs_n;
        code0 = bus.code;
        v_edge = -1; v_cnt = 0; gs_edge = -1; code_edge = -1;
        @(negedge clk);
        bus.key_n = key;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) begin
                v_cnt++;
                if (v_edge < 0) v_edge = k;
            end
            if (gs_edge < 0 && bus.gs_n !== gs0) gs_edge = k;
            if (code_edge < 0 && bus.code !== code0) code_edge = k;
        end
        code_o = bus.code;
        gs_o   = bus.gs_n;
    endtask

    int         ve, vc, ge, ce;
    logic [2:0] co;
    logic       go;

    task automatic test_reset();
        n_checks++; if (bus.code !== 3'd0) begin n_fails++; $display("FAIL reset_code: got %0d want 0", bus.code); end
        n_checks++; if (bus.valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_checks++; if (bus.gs_n !== 1'b1) begin n_fails++; $display("FAIL reset_gs_n: got %b want 1", bus.gs_n); end
    endtask

    task automatic test_single_press();
        observe(8'hF7, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7) begin n_fails++; $display("FAIL press_valid_edge: got %0d want 7", ve); end
        n_checks++; if (vc !== 1) begin n_fails++; $display("FAIL press_valid_cycles: got %0d want 1", vc); end
        n_checks++; if (ce !== 7) begin n_fails++; $display("FAIL press_code_edge: got %0d want 7", ce); end
        n_checks++; if (ge !== 7) begin n_fails++; $display("FAIL press_gs_edge: got %0d want 7", ge); end
        n_checks++; if (co !== 3'd3) begin n_fails++; $display("FAIL press_code: got %0d want 3", co); end
        n_checks++; if (go !== 1'b0) begin n_fails++; $display("FAIL press_gs_n: got %b want 0", go); end
        observe(8'hFF, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (vc !== 0) begin n_fails++; $display("FAIL release_valid: got %0d want 0", vc); end
        n_checks++; if (ge !== 7) begin n_fails++; $display("FAIL release_gs_edge: got %0d want 7", ge); end
        n_checks++; if (co !== 3'd3) begin n_fails++; $display("FAIL release_code_hold: got %0d want 3", co); end
    endtask

    task automatic test_bounce();
        int v_seen, gs_low;
        v_seen = 0; gs_low = 0;
        for (int r = 0; r < 5; r++) begin
            @(negedge clk); bus.key_n = 8'hFE;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                if (bus.valid !== 1'b0) v_seen++;
                if (bus.gs_n !== 1'b1) gs_low++;
            end
            @(negedge clk); bus.key_n = 8'hFF;
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (bus.valid !== 1'b0) v_seen++;
                if (bus.gs_n !== 1'b1) gs_low++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.valid !== 1'b0) v_seen++;
            if (bus.gs_n !== 1'b1) gs_low++;
        end
        n_checks++; if (v_seen !== 0) begin n_fails++; $display("FAIL bounce_valid: got %0d strobe cycles want 0", v_seen); end
        n_checks++; if (gs_low !== 0) begin n_fails++; $display("FAIL bounce_gs_n: got %0d low cycles want 0", gs_low); end
    endtask

    task automatic test_priority_mask();
        observe(8'h5B, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1) begin n_fails++; $display("FAIL multi_valid: got edge %0d count %0d want 7/1", ve, vc); end
        n_checks++; if (co !== 3'd7) begin n_fails++; $display("FAIL multi_code: got %0d want 7", co); end
        observe(8'h5F, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (vc !== 0) begin n_fails++; $display("FAIL lower_change_valid: got %0d want 0", vc); end
        n_checks++; if (co !== 3'd7 || go !== 1'b0) begin n_fails++; $display("FAIL lower_change_hold: got code %0d gs_n %b want 7/0", co, go); end
        observe(8'hDB, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1) begin n_fails++; $display("FAIL winner_drop_valid: got edge %0d count %0d want 7/1", ve, vc); end
        n_checks++; if (co !== 3'd5) begin n_fails++; $display("FAIL winner_drop_code: got %0d want 5", co); end
        observe(8'hFF, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (vc !== 0 || ge !== 7 || co !== 3'd5) begin n_fails++; $display("FAIL multi_release: got valid %0d gs_edge %0d code %0d want 0/7/5", vc, ge, co); end
    endtask

    task automatic test_add_release();
        observe(8'hFB, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || co !== 3'd2) begin n_fails++; $display("FAIL add_first: got edge %0d code %0d want 7/2", ve, co); end
        observe(8'hBB, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1 || co !== 3'd6) begin n_fails++; $display("FAIL add_higher: got edge %0d count %0d code %0d want 7/1/6", ve, vc, co); end
        observe(8'hFB, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1 || co !== 3'd2) begin n_fails++; $display("FAIL drop_higher: got edge %0d count %0d code %0d want 7/1/2", ve, vc, co); end
        observe(8'hFF, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (vc !== 0 || ge !== 7 || go !== 1'b1 || co !== 3'd2) begin n_fails++; $display("FAIL release_all: got valid %0d gs_edge %0d gs_n %b code %0d want 0/7/1/2", vc, ge, go, co); end
    endtask

    task automatic test_enable();
        observe(8'hEF, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || co !== 3'd4 || go !== 1'b0) begin n_fails++; $display("FAIL en_press: got edge %0d code %0d gs_n %b want 7/4/0", ve, co, go); end
        @(negedge clk); bus.en = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.gs_n !== 1'b1 || bus.code !== 3'd4 || bus.valid !== 1'b0) begin n_fails++; $display("FAIL en_clear: got gs_n %b code %0d valid %b want 1/4/0", bus.gs_n, bus.code, bus.valid); end
        bus.en = 1'b1;
        observe(8'hEF, 10, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1) begin n_fails++; $display("FAIL en_repress_valid: got edge %0d count %0d want 7/1", ve, vc); end
        n_checks++; if (ge !== 7 || co !== 3'd4) begin n_fails++; $display("FAIL en_repress_out: got gs_edge %0d code %0d want 7/4", ge, co); end
        observe(8'hFF, 10, ve, vc, ge, ce, co, go);
    endtask

    task automatic test_async_reset();
        @(negedge clk); bus.key_n = 8'h7F;
        for (int k = 0; k < 5; k++) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.code !== 3'd0 || bus.valid !== 1'b0 || bus.gs_n !== 1'b1) begin n_fails++; $display("FAIL async_reset_out: got code %0d valid %b gs_n %b want 0/0/1", bus.code, bus.valid, bus.gs_n); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        observe(8'h7F, 14, ve, vc, ge, ce, co, go);
        n_checks++; if (ve !== 7 || vc !== 1) begin n_fails++; $display("FAIL post_reset_valid: got edge %0d count %0d want 7/1", ve, vc); end
        n_checks++; if (co !== 3'd7 || go !== 1'b0) begin n_fails++; $display("FAIL post_reset_out: got code %0d gs_n %b want 7/0", co, go); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.key_n = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_press();
        test_bounce();
        test_priority_mask();
        test_add_release();
        test_enable();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
